mask_feeder: RTL and testbench

Frame-side sequencer for one skeletonization pass over the convolution unit. On a `start` pulse it streams all N*N pixels of the current frame from the single-port image RAM into the convolution unit's load port. It then captures the unit's write-back stream (enable, address, pixel) and writes every returned pixel into the same RAM. It also counts foreground pixels written back, so the iteration controller can detect convergence between passes.

---
 rtl/mask_feeder_if.sv | 26 ++
 rtl/mask_feeder.sv | 157 +++++++++++++++
 tb/tb_mask_feeder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mask_feeder_if.sv
// Image-RAM and convolution-unit bus of the mask feeder.
// The master side is the feeder; the slave side is the RAM plus convolution unit.
interface mask_feeder_if #(
  parameter int bitSize    = 6,
  parameter int pixelWidth = 8
);
  logic [bitSize:0]      ram_addr;
  logic                  ram_we;
  logic [pixelWidth-1:0] ram_wr_data;
  logic [pixelWidth-1:0] ram_rd_data;
  logic                  mask_we;
  logic [pixelWidth-1:0] mask_data;
  logic                  mask_wr_en;
  logic [bitSize:0]      mask_addr;
  logic [pixelWidth-1:0] mask_pixel;

  modport master (
    output ram_addr, ram_we, ram_wr_data, mask_we, mask_data,
    input  ram_rd_data, mask_wr_en, mask_addr, mask_pixel
  );

  modport slave (
    input  ram_addr, ram_we, ram_wr_data, mask_we, mask_data,
    output ram_rd_data, mask_wr_en, mask_addr, mask_pixel
  );
endinterface

// File: rtl/mask_feeder.sv
// Frame sequencer for one skeletonization pass: streams the frame to the convolution
// unit, writes its write-back burst into the image RAM and counts foreground pixels.
// Optional watchdog on the write-back wait: define MASK_FEEDER_TIMEOUT_EN.
module mask_feeder #(
  parameter int N              = 8,
  parameter int bitSize        = 6,
  parameter int pixelWidth     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [bitSize+1:0] fg_count,
  mask_feeder_if.master      bus
);

  localparam int CNT_W = bitSize + 2;
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(N * N);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N * N - 1);
  localparam logic [CNT_W-1:0] FG_MAX    = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] rd_cnt_reg;
  logic [CNT_W-1:0] fg_count_reg;
  logic [bitSize:0] addr_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             mask_we_reg;
  logic             wb_beat;
  logic             fg_hit;

`ifdef MASK_FEEDER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_reg;
  logic               err_reg;
`endif

  // The beat that wakes WAIT is already the first DRAIN beat, so it is written
  // in the same cycle; the write path is purely combinational for zero latency.
  assign wb_beat = bus.mask_wr_en && ((state_reg == ST_WAIT) || (state_reg == ST_DRAIN));
  assign fg_hit  = wb_beat && (bus.mask_pixel != '0);

  assign bus.ram_we      = wb_beat;
  assign bus.ram_addr    = wb_beat ? bus.mask_addr : addr_reg;
  assign bus.ram_wr_data = wb_beat ? bus.mask_pixel : '0;
  assign bus.mask_we     = mask_we_reg;
  // RAM read data arrives one cycle after the address, aligned with mask_we_reg.
  assign bus.mask_data   = mask_we_reg ? bus.ram_rd_data : '0;

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign fg_count = fg_count_reg;

`ifdef MASK_FEEDER_TIMEOUT_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      rd_cnt_reg   <= '0;
      fg_count_reg <= '0;
      addr_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      mask_we_reg  <= 1'b0;
`ifdef MASK_FEEDER_TIMEOUT_EN
      timer_reg    <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      done_reg    <= 1'b0;
      mask_we_reg <= 1'b0;

      if (fg_hit && (fg_count_reg != FG_MAX)) begin
        fg_count_reg <= fg_count_reg + 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_LOAD;
            busy_reg     <= 1'b1;
            rd_cnt_reg   <= '0;
            addr_reg     <= '0;
            fg_count_reg <= '0;
`ifdef MASK_FEEDER_TIMEOUT_EN
            timer_reg    <= '0;
            err_reg      <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          // rd_cnt reaching N*N marks the cycle the last pixel is on mask_data.
          if (rd_cnt_reg != TOTAL_CNT) begin
            rd_cnt_reg  <= rd_cnt_reg + 1'b1;
            mask_we_reg <= 1'b1;
            if (rd_cnt_reg != LAST_CNT) begin
              addr_reg <= addr_reg + 1'b1;
            end
          end else begin
            state_reg <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (bus.mask_wr_en) begin
            state_reg <= ST_DRAIN;
          end
`ifdef MASK_FEEDER_TIMEOUT_EN
          else if (timer_reg == TIMER_LAST) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
`endif
        end

        ST_DRAIN: begin
          if (!bus.mask_wr_en) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mask_feeder.sv
// Self-checking bench for mask_feeder (N=8): RAM model, load scoreboard, write-back,
// restart suppression, mid-pass reset and the optional watchdog.
module tb_mask_feeder;

  localparam int N    = 8;
  localparam int BS   = 6;
  localparam int PW   = 8;
  localparam int NPIX = N * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [BS+1:0] fg_count;

  mask_feeder_if #(.bitSize(BS), .pixelWidth(PW)) bus ();

  mask_feeder #(
    .N(N), .bitSize(BS), .pixelWidth(PW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .fg_count (fg_count),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // Single-port image RAM model with one-cycle registered read.
  logic [PW-1:0] mem [0:(1<<(BS+1))-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= mem[bus.ram_addr];
  end

  int tests_run    = 0;
  int tests_failed = 0;

  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] got_q [$];
  int            first_idx, last_idx, we_count, done_count, done_idx;
  logic          ram_we_seen, busy0, err_at_done;
  logic [BS:0]   addr0;
  logic [BS+1:0] fg_at_done;
  logic [35:0]   obs;

  // Pulses start, then records the load stream; index 0 is the first LOAD cycle.
  task automatic capture_load(input int ncycles, input int pulse_at, input int stop_after);
    got_q.delete();
    first_idx = -1; last_idx = -1; we_count = 0; done_count = 0; done_idx = -1;
    ram_we_seen = 1'b0; err_at_done = 1'b0; fg_at_done = '0;
    @(posedge clk); #1 start = 1'b1;
    for (int idx = 0; idx < ncycles; idx++) begin
      @(posedge clk); #1 start = (idx == pulse_at);
      @(negedge clk);
      if (idx == 0) begin addr0 = bus.ram_addr; busy0 = busy; end
      if (bus.ram_we) ram_we_seen = 1'b1;
      if (done) begin
        done_count++;
        if (done_idx < 0) begin done_idx = idx; err_at_done = err; fg_at_done = fg_count; end
      end
      if (bus.mask_we) begin
        if (first_idx < 0) first_idx = idx;
        last_idx = idx;
        we_count++;
        got_q.push_back(bus.mask_data);
      end
      if (stop_after > 0 && we_count == stop_after) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    bus.mask_wr_en = 1'b0; bus.mask_addr = '0; bus.mask_pixel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {busy, done, err, fg_count, bus.ram_addr, bus.ram_we, bus.ram_wr_data, bus.mask_we, bus.mask_data};
    tests_run++;
    if (obs !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h, expected 0", obs); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      obs = {busy, done, err, fg_count, bus.ram_addr, bus.ram_we, bus.ram_wr_data, bus.mask_we, bus.mask_data};
      tests_run++;
      if (obs !== '0) begin tests_failed++; $display("FAIL idle_outputs[%0d]: got %h, expected 0", c, obs); end
    end
  endtask

  task automatic test_load();
    logic [PW-1:0] e, g;
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin mem[k] = PW'(k); exp_q.push_back(PW'(k)); end
    capture_load(70, -1, 0);
    tests_run++;
    if (addr0 !== '0 || busy0 !== 1'b1) begin
      tests_failed++; $display("FAIL load_first_cycle: addr %0d busy %b, expected addr 0 busy 1", addr0, busy0);
    end
    tests_run++;
    if (first_idx != 1 || last_idx != NPIX || we_count != NPIX) begin
      tests_failed++;
      $display("FAIL load_window: first %0d last %0d count %0d, expected 1 %0d %0d", first_idx, last_idx, we_count, NPIX, NPIX);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL load_data: got %0d, expected %0d", g, e); end
    end
    tests_run++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      tests_failed++; $display("FAIL load_count: leftover expected %0d got %0d, expected 0 0", exp_q.size(), got_q.size());
    end
    tests_run++;
    if (ram_we_seen !== 1'b0) begin tests_failed++; $display("FAIL load_ram_we: got 1, expected 0"); end
  endtask

  // Continues from WAIT left by test_load.
  task automatic test_writeback();
    logic [PW-1:0] p;
    for (int i = 0; i < NPIX; i++) begin
      p = (i % 2 == 0) ? PW'(1) : PW'(0);
      @(posedge clk); #1 bus.mask_wr_en = 1'b1; bus.mask_addr = (BS+1)'(i); bus.mask_pixel = p;
      @(negedge clk);
      tests_run++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_wr_data, done} !== {1'b1, (BS+1)'(i), p, 1'b0}) begin
        tests_failed++;
        $display("FAIL wb_beat[%0d]: we %b addr %0d data %0d done %b, expected 1 %0d %0d 0",
                 i, bus.ram_we, bus.ram_addr, bus.ram_wr_data, done, i, p);
      end
    end
    @(posedge clk); #1 bus.mask_wr_en = 1'b0; bus.mask_pixel = '0;
    @(negedge clk);
    tests_run++;
    if ({bus.ram_we, done} !== 2'b00) begin
      tests_failed++; $display("FAIL wb_gap: we %b done %b, expected 0 0", bus.ram_we, done);
    end
    @(negedge clk);
    tests_run++;
    if ({done, busy, err} !== 3'b110 || fg_count !== 8'd32) begin
      tests_failed++; $display("FAIL wb_done: done %b busy %b err %b fg %0d, expected 1 1 0 32", done, busy, err, fg_count);
    end
    @(negedge clk);
    tests_run++;
    if ({done, busy} !== 2'b00 || fg_count !== 8'd32) begin
      tests_failed++; $display("FAIL wb_after_done: done %b busy %b fg %0d, expected 0 0 32", done, busy, fg_count);
    end
    for (int i = 0; i < NPIX; i++) begin
      p = (i % 2 == 0) ? PW'(1) : PW'(0);
      tests_run++;
      if (mem[i] !== p) begin tests_failed++; $display("FAIL wb_ram[%0d]: got %0d, expected %0d", i, mem[i], p); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [PW-1:0] e, g;
    int wb_done;
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin mem[k] = PW'(200 - k); exp_q.push_back(PW'(200 - k)); end
    capture_load(70, 20, 0);
    tests_run++;
    if (first_idx != 1 || we_count != NPIX) begin
      tests_failed++; $display("FAIL busy_load_window: first %0d count %0d, expected 1 %0d", first_idx, we_count, NPIX);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL busy_load_data: got %0d, expected %0d", g, e); end
    end
    wb_done = 0;
    for (int i = 0; i < NPIX; i++) begin
      @(posedge clk); #1 bus.mask_wr_en = 1'b1; bus.mask_addr = (BS+1)'(NPIX - 1 - i);
      bus.mask_pixel = PW'(i); start = (i == 10);
      @(negedge clk);
      if (done) wb_done++;
    end
    @(posedge clk); #1 bus.mask_wr_en = 1'b0; bus.mask_pixel = '0; start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) wb_done++;
    end
    tests_run++;
    if (done_count + wb_done != 1) begin
      tests_failed++; $display("FAIL busy_done_pulses: got %0d, expected 1", done_count + wb_done);
    end
    tests_run++;
    if (fg_count !== 8'd63 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL busy_fg_count: fg %0d busy %b, expected 63 0", fg_count, busy);
    end
    for (int i = 0; i < NPIX; i++) begin
      tests_run++;
      if (mem[NPIX - 1 - i] !== PW'(i)) begin
        tests_failed++; $display("FAIL busy_ram[%0d]: got %0d, expected %0d", NPIX - 1 - i, mem[NPIX - 1 - i], i);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [PW-1:0] e, g;
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin mem[k] = PW'(k) ^ 8'h5A; exp_q.push_back(PW'(k) ^ 8'h5A); end
    capture_load(70, -1, 30);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    obs = {busy, done, err, fg_count, bus.ram_addr, bus.ram_we, bus.ram_wr_data, bus.mask_we, bus.mask_data};
    tests_run++;
    if (obs !== '0) begin tests_failed++; $display("FAIL midreset_outputs: got %h, expected 0", obs); end
    tests_run++;
    if (we_count != 30) begin tests_failed++; $display("FAIL midreset_partial: got %0d beats, expected 30", we_count); end
    while (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL midreset_partial_data: got %0d, expected %0d", g, e); end
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < NPIX; k++) exp_q.push_back(PW'(k) ^ 8'h5A);
    capture_load(70, -1, 0);
    tests_run++;
    if (addr0 !== '0 || first_idx != 1 || we_count != NPIX) begin
      tests_failed++;
      $display("FAIL midreset_replay: addr %0d first %0d count %0d, expected 0 1 %0d", addr0, first_idx, we_count, NPIX);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL midreset_replay_data: got %0d, expected %0d", g, e); end
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_watchdog();
    for (int k = 0; k < NPIX; k++) mem[k] = '0;
`ifdef MASK_FEEDER_TIMEOUT_EN
    // WAIT is entered at index NPIX+1; the timeout lands 16 cycles later.
    capture_load(100, -1, 0);
    tests_run++;
    if (done_idx != NPIX + 1 + 16 || done_count != 1) begin
      tests_failed++; $display("FAIL watchdog_done: at %0d count %0d, expected %0d 1", done_idx, done_count, NPIX + 17);
    end
    tests_run++;
    if (err_at_done !== 1'b1 || fg_at_done !== '0) begin
      tests_failed++; $display("FAIL watchdog_err: err %b fg %0d, expected 1 0", err_at_done, fg_at_done);
    end
    tests_run++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL watchdog_hold: err %b busy %b, expected 1 0", err, busy);
    end
`else
    capture_load(200, -1, 0);
    tests_run++;
    if (done_count != 0 || busy !== 1'b1 || err !== 1'b0) begin
      tests_failed++; $display("FAIL wait_forever: done %0d busy %b err %b, expected 0 1 0", done_count, busy, err);
    end
`endif
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_writeback();
    test_start_while_busy();
    test_mid_reset();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
